// File: rtl/sine_pwm_sequencer.sv
// Sine PWM sequencer: phase accumulator addressing a registered sine LUT, amplitude
// scaling, double-buffered PWM compare value and run/stop/drain sequencing.
//
// state    | meaning
// ST_IDLE  | stopped; config writes accepted; pwm_cnt and duty held at 0
// ST_RUN   | PWM running; phase advances once every max(div,1) PWM periods
// ST_DRAIN | still running; returns to idle when the phase completes the sine cycle
module sine_pwm_sequencer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int PWM_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_addr,
    input  logic [15:0]       cfg_data,
    input  logic              start,
    input  logic              stop,
    input  logic              abort,
    output logic [ADDR_W-1:0] lut_addr,
    input  logic [DATA_W-1:0] lut_data,
    output logic [DATA_W-1:0] duty,
    output logic [PWM_W-1:0]  pwm_cnt,
    output logic              pwm,
    output logic              period_tick,
    output logic [7:0]        update_c,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [PWM_W-1:0] CNT_MAX = '1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   phase_q, phase_d;
    logic [DATA_W-1:0]   shadow_q, shadow_d;
    logic [DATA_W-1:0]   duty_q, duty_d;
    logic [PWM_W-1:0]    pwm_cnt_q, pwm_cnt_d;
    logic [15:0]         div_cnt_q, div_cnt_d;
    logic [7:0]          update_c_q, update_c_d;
    logic                done_q, done_d;
    logic [ADDR_W-1:0]   step_q, step_d;
    logic [15:0]         div_q, div_d;
    logic [DATA_W-1:0]   amp_q, amp_d;

    logic                busy_w;
    logic                tick_w;
    logic [15:0]         div_eff;
    logic                div_hit;
    logic [ADDR_W:0]     phase_sum;
    logic                drain_exit;
    logic [DATA_W:0]     amp_p1;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   scaled;

    assign busy_w  = (state_q != ST_IDLE);
    assign tick_w  = busy_w && (pwm_cnt_q == CNT_MAX);
    assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;
    assign div_hit = (div_cnt_q == div_eff - 16'd1);

    // Carry out of the accumulator marks the end of a sine cycle.
    assign phase_sum  = {1'b0, phase_q} + {1'b0, step_q};
    assign drain_exit = (state_q == ST_DRAIN) &&
                        ((tick_w && div_hit && (phase_sum[ADDR_W] ||
                                                (phase_sum[ADDR_W-1:0] == '0))) ||
                         (tick_w && (step_q == '0)));

    // (amp+1) scaling makes amp = all-ones an exact identity after the shift.
    assign amp_p1 = {1'b0, amp_q} + (DATA_W+1)'(1);
    assign prod   = {{DATA_W{1'b0}}, lut_data} * {{(DATA_W-1){1'b0}}, amp_p1};
    assign scaled = DATA_W'(prod >> DATA_W);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        shadow_d   = shadow_q;
        duty_d     = duty_q;
        pwm_cnt_d  = pwm_cnt_q;
        div_cnt_d  = div_cnt_q;
        update_c_d = update_c_q;
        done_d     = 1'b0;
        step_d     = step_q;
        div_d      = div_q;
        amp_d      = amp_q;

        if (busy_w) begin
            shadow_d = scaled;
        end

        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    case (cfg_addr)
                        2'd0:    step_d = cfg_data[ADDR_W-1:0];
                        2'd1:    div_d  = cfg_data;
                        2'd2:    amp_d  = cfg_data[DATA_W-1:0];
                        default: ;
                    endcase
                end
                if (start && !stop && !abort) begin
                    state_d    = ST_RUN;
                    phase_d    = '0;
                    pwm_cnt_d  = '0;
                    div_cnt_d  = '0;
                    duty_d     = '0;
                    update_c_d = '0;
                end
            end
            default: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    pwm_cnt_d = '0;
                    duty_d    = '0;
                end else begin
                    pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
                    if (tick_w) begin
                        duty_d = shadow_q;
                        if (div_hit) begin
                            phase_d    = phase_sum[ADDR_W-1:0];
                            update_c_d = update_c_q + 8'd1;
                            div_cnt_d  = '0;
                        end else begin
                            div_cnt_d = div_cnt_q + 16'd1;
                        end
                    end
                    if (drain_exit) begin
                        state_d   = ST_IDLE;
                        pwm_cnt_d = '0;
                        duty_d    = '0;
                        done_d    = 1'b1;
                    end else if ((state_q == ST_RUN) && stop) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            shadow_q   <= '0;
            duty_q     <= '0;
            pwm_cnt_q  <= '0;
            div_cnt_q  <= '0;
            update_c_q <= '0;
            done_q     <= 1'b0;
            step_q     <= ADDR_W'(1);
            div_q      <= 16'd1;
            amp_q      <= '1;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            shadow_q   <= shadow_d;
            duty_q     <= duty_d;
            pwm_cnt_q  <= pwm_cnt_d;
            div_cnt_q  <= div_cnt_d;
            update_c_q <= update_c_d;
            done_q     <= done_d;
            step_q     <= step_d;
            div_q      <= div_d;
            amp_q      <= amp_d;
        end
    end

    assign cfg_ready   = (state_q == ST_IDLE);
    assign lut_addr    = phase_q;
    assign duty        = duty_q;
    assign pwm_cnt     = pwm_cnt_q;
    assign period_tick = tick_w;
    assign update_c    = update_c_q;
    assign busy        = busy_w;
    assign done        = done_q;
    assign pwm         = busy_w &&
                         ({{DATA_W{1'b0}}, pwm_cnt_q} < {{PWM_W{1'b0}}, duty_q});

endmodule

// File: tb/tb_sine_pwm_sequencer.sv
// Bench for sine_pwm_sequencer: period-level behavioural model checked every cycle,
// directed scenarios with literal expectations, then randomized command traffic.
module tb_sine_pwm_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_addr = 2'd0;
    logic [15:0] cfg_data = 16'd0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  lut_addr;
    logic [7:0]  lut_data = 8'd0;
    logic [7:0]  duty;
    logic [7:0]  pwm_cnt;
    logic        pwm;
    logic        period_tick;
    logic [7:0]  update_c;
    logic        busy;
    logic        done;

    int lut_mode  = 0;
    int lut_const = 0;
    int n_checks  = 0;
    int n_errors  = 0;

    // Model state: mode 0 idle, 1 run, 2 drain; m_cyc counts clocks since start.
    int m_mode, m_cyc, m_phase, m_adv, m_duty, m_done, m_step, m_div, m_amp;

    always #5 clk = ~clk;

    sine_pwm_sequencer #(.ADDR_W(8), .DATA_W(8), .PWM_W(8)) dut (
        .clk(clk), .reset(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .stop(stop), .abort(abort),
        .lut_addr(lut_addr), .lut_data(lut_data),
        .duty(duty), .pwm_cnt(pwm_cnt), .pwm(pwm), .period_tick(period_tick),
        .update_c(update_c), .busy(busy), .done(done)
    );

    function automatic int lut_fn(input int mode, input int c, input int a);
        if (mode == 0) return a & 255;
        else if (mode == 1) return c & 255;
        else return (a * 37 + 11) & 255;
    endfunction

    function automatic int scale(input int s, input int a);
        return (s * (a + 1)) / 256;
    endfunction

    always @(posedge clk) lut_data <= 8'(lut_fn(lut_mode, lut_const, int'(lut_addr)));

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
            if (n_errors >= 60) finish_sim();
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_cyc = 0; m_phase = 0; m_adv = 0; m_duty = 0; m_done = 0;
        m_step = 1; m_div = 1; m_amp = 255;
    endtask

    // One clock of the model from the inputs that were present at the last rising edge.
    task automatic model_step();
        int tick, adv_now, ex, sum, d;
        m_done = 0;
        if (m_mode == 0) begin
            if (cfg_valid) begin
                if (cfg_addr == 2'd0) m_step = int'(cfg_data) & 255;
                else if (cfg_addr == 2'd1) m_div = int'(cfg_data);
                else if (cfg_addr == 2'd2) m_amp = int'(cfg_data) & 255;
            end
            if (start && !stop && !abort) begin
                m_mode = 1; m_cyc = 0; m_adv = 0; m_phase = 0; m_duty = 0;
            end
        end else if (abort) begin
            m_mode = 0; m_cyc = 0; m_duty = 0;
        end else begin
            tick    = int'((m_cyc % 256) == 255);
            d       = (m_div == 0) ? 1 : m_div;
            adv_now = int'(tick != 0 && (((m_cyc / 256) + 1) % d) == 0);
            ex      = 0;
            if (tick != 0) m_duty = scale(lut_fn(lut_mode, lut_const, m_phase), m_amp);
            if (adv_now != 0) begin
                sum = m_phase + m_step;
                if (m_mode == 2 && (sum >= 256 || (sum % 256) == 0)) ex = 1;
                m_phase = sum % 256;
                m_adv++;
            end
            if (m_mode == 2 && m_step == 0 && tick != 0) ex = 1;
            if (ex != 0) begin
                m_mode = 0; m_duty = 0; m_done = 1; m_cyc = 0;
            end else begin
                if (m_mode == 1 && stop) m_mode = 2;
                m_cyc++;
            end
        end
    endtask

    initial begin
        int be, pc;
        model_reset();
        forever begin
            @(negedge clk);
            if (rst) model_reset();
            else model_step();
            be = int'(m_mode != 0);
            pc = (be != 0) ? (m_cyc % 256) : 0;
            check("busy", int'(busy), be);
            check("cfg_ready", int'(cfg_ready), 1 - be);
            check("pwm_cnt", int'(pwm_cnt), pc);
            check("period_tick", int'(period_tick), int'(be != 0 && pc == 255));
            check("lut_addr", int'(lut_addr), m_phase);
            check("duty", int'(duty), m_duty);
            check("pwm", int'(pwm), int'(be != 0 && pc < m_duty));
            check("update_c", int'(update_c), m_adv % 256);
            check("done", int'(done), m_done);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input int a, input int d);
        cfg_valid = 1'b1; cfg_addr = 2'(a); cfg_data = 16'(d);
        cyc(1);
        cfg_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
    endtask

    task automatic rand_run(input int ncyc);
        int a;
        do_abort();
        lut_mode  = $urandom_range(0, 2);
        lut_const = $urandom_range(0, 255);
        repeat ($urandom_range(1, 4)) begin
            a = $urandom_range(0, 3);
            cfg_write(a, (a == 1) ? $urandom_range(0, 3) : $urandom_range(0, 65535));
        end
        for (int i = 0; i < ncyc; i++) begin
            start = ($urandom_range(0, 39) == 0);
            stop  = ($urandom_range(0, 299) == 0);
            abort = ($urandom_range(0, 1999) == 0);
            if ($urandom_range(0, 29) == 0) begin
                a = $urandom_range(0, 3);
                cfg_valid = 1'b1;
                cfg_addr  = 2'(a);
                cfg_data  = 16'((a == 1) ? $urandom_range(0, 3) : $urandom_range(0, 65535));
            end else begin
                cfg_valid = 1'b0;
            end
            cyc(1);
        end
        start = 1'b0; stop = 1'b0; abort = 1'b0; cfg_valid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        n_errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        finish_sim();
    end

    initial begin
        int cnt;
        rst = 1'b1;
        cyc(3);
        check("rst_cfg_ready", int'(cfg_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_duty", int'(duty), 0);
        check("rst_update_c", int'(update_c), 0);
        rst = 1'b0;
        cyc(2);

        // Reset in the middle of a run clears outputs within the same timestep.
        lut_mode = 0;
        do_start();
        cyc(100);
        check("t1_pwm_cnt_before", int'(pwm_cnt), 100);
        #2 rst = 1'b1;
        #1;
        check("t1_busy", int'(busy), 0);
        check("t1_pwm", int'(pwm), 0);
        check("t1_duty", int'(duty), 0);
        check("t1_pwm_cnt", int'(pwm_cnt), 0);
        check("t1_update_c", int'(update_c), 0);
        cyc(2);
        rst = 1'b0;
        cyc(1);
        do_start();
        cyc(520);
        check("t1_default_step", int'(lut_addr), 2);
        check("t1_default_upd", int'(update_c), 2);
        check("t1_default_amp", int'(duty), 1);
        do_abort();

        // step=4, div=2, identity LUT.
        cfg_write(0, 4);
        cfg_write(1, 2);
        do_start();
        cyc(511);
        check("t2_addr_511", int'(lut_addr), 0);
        cyc(1);
        check("t2_addr_512", int'(lut_addr), 4);
        cyc(7);
        check("t2_upd_519", int'(update_c), 1);
        check("t2_duty_519", int'(duty), 0);
        cyc(510);
        check("t2_addr_1029", int'(lut_addr), 8);
        check("t2_upd_1029", int'(update_c), 2);
        check("t2_duty_1029", int'(duty), 4);
        cyc(520);
        check("t2_upd_1549", int'(update_c), 3);
        do_abort();

        // Constant LUT 200, amp 127: duty 100, 100 high clocks per period.
        cfg_write(2, 127);
        lut_mode = 1; lut_const = 200;
        do_start();
        cyc(256);
        check("t3_duty", int'(duty), 100);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            cnt += int'(pwm);
            cyc(1);
        end
        check("t3_high_count", cnt, 100);
        do_abort();
        lut_const = 0;
        do_start();
        cnt = 0;
        for (int i = 0; i < 600; i++) begin
            cnt += int'(pwm);
            cyc(1);
        end
        check("t3_zero_high_count", cnt, 0);
        do_abort();

        // Graceful stop at phase 128 with step 64: drains through 192 to 0.
        cfg_write(0, 64);
        cfg_write(1, 1);
        cfg_write(2, 255);
        lut_mode = 2;
        do_start();
        cyc(600);
        check("t4_phase_at_stop", int'(lut_addr), 128);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        cyc(422);
        check("t4_addr_1023", int'(lut_addr), 192);
        check("t4_busy_1023", int'(busy), 1);
        cyc(1);
        check("t4_done", int'(done), 1);
        check("t4_busy", int'(busy), 0);
        check("t4_pwm", int'(pwm), 0);
        check("t4_addr", int'(lut_addr), 0);
        check("t4_upd", int'(update_c), 4);
        cyc(1);
        check("t4_done_pulse", int'(done), 0);

        // Config write stalls during RUN and lands in the first idle cycle after abort.
        lut_mode = 1; lut_const = 255;
        do_start();
        cyc(10);
        cfg_valid = 1'b1; cfg_addr = 2'd2; cfg_data = 16'd50;
        cyc(290);
        check("t5_cfg_ready_run", int'(cfg_ready), 0);
        check("t5_amp_unchanged", int'(duty), 255);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        check("t5_cfg_ready_idle", int'(cfg_ready), 1);
        cyc(1);
        cfg_valid = 1'b0;
        do_start();
        cyc(300);
        check("t5_amp_50", int'(duty), 50);
        do_abort();

        // div=0 advances every period; step=0 drain exits at the next period tick.
        cfg_write(1, 0);
        cfg_write(0, 3);
        lut_mode = 0;
        do_start();
        cyc(520);
        check("t6_div0_upd", int'(update_c), 2);
        check("t6_div0_addr", int'(lut_addr), 6);
        do_abort();
        cfg_write(0, 0);
        do_start();
        cyc(100);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        cyc(154);
        check("t6_tick_busy", int'(busy), 1);
        check("t6_tick", int'(period_tick), 1);
        cyc(1);
        check("t6_step0_done", int'(done), 1);
        check("t6_step0_idle", int'(busy), 0);
        start = 1'b1; stop = 1'b1;
        cyc(1);
        start = 1'b0; stop = 1'b0;
        check("t6_start_stop", int'(busy), 0);
        cyc(2);
        check("t6_start_stop_later", int'(busy), 0);

        for (int r = 0; r < 14; r++) rand_run(1200);

        cyc(2);
        finish_sim();
    end

endmodule
